// File: rtl/cla_pkg.sv
// Shared word width and FSM encoding for the word-serial
// carry-lookahead adder.
package cla_pkg;

    localparam int W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla64bits.sv
// 64-bit carry-lookahead adder: 4-bit lookahead groups chained
// through group generate/propagate terms.
module cla64bits
    import cla_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         gen,
    output logic         prop
);

    localparam int NG = W / 4;

    logic [W-1:0] w_g;
    logic [W-1:0] w_p;

    assign w_g = a & b;
    assign w_p = a ^ b;

    always_comb begin
        logic       c;
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] cg;
        logic       gg;
        logic       gp;
        c    = cin;
        g    = '0;
        p    = '0;
        cg   = '0;
        gg   = 1'b0;
        gp   = 1'b0;
        sum  = '0;
        gen  = 1'b0;
        prop = 1'b1;
        for (int k = 0; k < NG; k++) begin
            g     = w_g[4*k +: 4];
            p     = w_p[4*k +: 4];
            gg    = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1])
                  | (&p[3:1] & g[0]);
            gp    = &p;
            cg[0] = c;
            cg[1] = g[0] | (p[0] & c);
            cg[2] = g[1] | (p[1] & g[0]) | (&p[1:0] & c);
            cg[3] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0])
                  | (&p[2:0] & c);
            cg[4] = gg | (gp & c);
            sum[4*k +: 4] = p ^ cg[3:0];
            gen   = gg | (gp & gen);
            prop  = prop & gp;
            c     = cg[4];
        end
        cout = c;
    end

endmodule

// File: rtl/cla_word_seq.sv
// Multi-word add/subtract: one 64-bit CLA reused once per word,
// carry held in a register between words.
module cla_word_seq
    import cla_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               op_sub,
    input  logic               cin,
    input  logic [WORDS*W-1:0] a,
    input  logic [WORDS*W-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORDS*W-1:0] sum,
    output logic               cout,
    output logic               ovf,
    output logic               busy
);

    localparam int            IW   = $clog2(WORDS);
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic                    r_carry;
    logic                    r_ovf;
    logic [WORDS-1:0][W-1:0] r_a;
    logic [WORDS-1:0][W-1:0] r_b;
    logic [WORDS-1:0][W-1:0] r_sum;

    logic [W-1:0] w_sum;
    logic         w_cout;
    logic         w_gen;
    logic         w_prop;
    logic         w_unused;
    logic         w_accept;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_carry;
    assign ovf       = r_ovf;
    assign w_accept  = in_ready && in_valid;
    assign w_unused  = w_gen ^ w_prop;

    cla64bits u_cla (
        .a    (r_a[r_idx]),
        .b    (r_b[r_idx]),
        .cin  (r_carry),
        .sum  (w_sum),
        .cout (w_cout),
        .gen  (w_gen),
        .prop (w_prop)
    );

    // Subtraction is a + ~b + 1, so B is stored already inverted.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= a;
            r_b <= op_sub ? ~b : b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
            r_sum   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_carry <= op_sub | cin;
                        r_idx   <= '0;
                        r_state <= ADD;
                    end
                end
                ADD: begin
                    r_sum[r_idx] <= w_sum;
                    r_carry      <= w_cout;
                    r_idx        <= r_idx + IW'(1);
                    if (r_idx == LAST) begin
                        r_ovf   <= (r_a[WORDS-1][W-1] == r_b[WORDS-1][W-1])
                                && (w_sum[W-1] != r_a[WORDS-1][W-1]);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_word_seq.sv
// Bench for cla_word_seq: directed literal cases plus a randomized
// regression against a whole-operand arithmetic model.
module tb_cla_word_seq;

    localparam int WORDS = 4;
    localparam int N     = WORDS * 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic         cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int n_acc     = 0;
    bit rnd_phase = 1'b0;

    typedef struct {
        logic [N-1:0] s;
        logic         c;
        logic         o;
        int           acc;
        bit           seen;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    cla_word_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .cin       (cin),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Unsigned result/carry and signed overflow from plain arithmetic.
    function automatic exp_t model(input logic [N-1:0] x,
                                   input logic [N-1:0] y,
                                   input logic sub, input logic ci);
        exp_t       e;
        logic [N:0] u;
        logic [N:0] sg;
        if (sub) begin
            u  = {1'b0, x} - {1'b0, y};
            sg = {x[N-1], x} - {y[N-1], y};
            e.c = (x >= y);
        end else begin
            u  = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};
            sg = {x[N-1], x} + {y[N-1], y} + {{N{1'b0}}, ci};
            e.c = u[N];
        end
        e.s    = u[N-1:0];
        e.o    = sg[N] ^ sg[N-1];
        e.acc  = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] r;
        for (int i = 0; i < N / 32; i++) r[i*32 +: 32] = $urandom;
        case ($urandom % 10)
            0: r = '1;
            1: r = '0;
            2: r = {1'b0, {(N-1){1'b1}}};
            3: r = N'(1);
            4: r = {1'b1, {(N-1){1'b0}}};
            default: ;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("in_ready_vs_busy", in_ready, !busy);
            if (out_valid) begin
                chk("in_ready_in_done", in_ready, 1'b0);
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out_valid: got 1 expected 0");
                end else begin
                    if (!q[0].seen) begin
                        chk("latency", cyc - q[0].acc, WORDS);
                        q[0].seen = 1'b1;
                    end
                    chk("sum", sum, q[0].s);
                    chk("cout", cout, q[0].c);
                    chk("ovf", ovf, q[0].o);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                m_e     = model(a, b, op_sub, cin);
                m_e.acc = cyc + 1;
                q.push_back(m_e);
                n_acc++;
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_phase) begin
            #2;
            out_ready = ($urandom % 4) != 0;
        end
    end

    task automatic drive(input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic sub, input logic ci);
        a        = x;
        b        = y;
        op_sub   = sub;
        cin      = ci;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = rnd();
        b        = rnd();
        op_sub   = 1'($urandom);
        cin      = 1'($urandom);
        chk("accepted", busy, 1'b1);
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!out_valid && k < 64) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_after_consume", {out_valid, in_ready}, 2'b01);
    endtask

    task automatic directed(input string nm,
                            input logic [N-1:0] x, input logic [N-1:0] y,
                            input logic sub, input logic ci,
                            input logic [N-1:0] es,
                            input logic ec, input logic eo);
        int k;
        drive(x, y, sub, ci);
        wait_done(k);
        chk({nm, "_lat"}, k, WORDS);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"}, ovf, eo);
        consume();
    endtask

    initial begin
        logic [N-1:0] held;
        logic [N-1:0] lo_ones;
        int           k;
        int           guard;
        int           n0;

        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_sub    = 1'b0;
        cin       = 1'b0;
        a         = '0;
        b         = '0;
        rst_n     = 1'b1;
        #1;
        rst_n = 1'b0;
        #2;
        chk("reset_flags", {in_ready, out_valid, busy, cout, ovf}, 5'b10000);
        chk("reset_sum", sum, '0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        directed("ones_plus_one", '1, N'(1), 1'b0, 1'b0, '0, 1'b1, 1'b0);
        directed("sub_5_7", N'(5), N'(7), 1'b1, 1'b1, ~N'(1), 1'b0, 1'b0);
        directed("max_plus_one", {1'b0, {(N-1){1'b1}}}, N'(1), 1'b0, 1'b0,
                 {1'b1, {(N-1){1'b0}}}, 1'b0, 1'b1);
        directed("neg1_neg1_cin", '1, '1, 1'b0, 1'b1, '1, 1'b1, 1'b0);
        directed("sub_equal", N'(9), N'(9), 1'b1, 1'b0, '0, 1'b1, 1'b0);

        drive(rnd(), rnd(), 1'b0, 1'b1);
        wait_done(k);
        chk("bp_lat", k, WORDS);
        held     = sum;
        in_valid = 1'b1;
        repeat (10) begin
            a = rnd();
            @(posedge clk);
            #1;
            chk("bp_sum_stable", sum, held);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle", {out_valid, in_ready, busy}, 3'b010);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_next_accept", busy, 1'b1);
        wait_done(k);
        consume();

        drive(rnd(), rnd(), 1'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_flags", {out_valid, busy, in_ready, cout, ovf}, 5'b00100);
        chk("rst_mid_sum", sum, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        lo_ones = {{(N-64){1'b0}}, {64{1'b1}}};
        directed("post_rst", lo_ones, N'(1), 1'b0, 1'b0,
                 N'(1) << 64, 1'b0, 1'b0);

        n0        = n_acc;
        guard     = 0;
        rnd_phase = 1'b1;
        while ((n_acc - n0) < 10000 && guard < 85000) begin
            a        = rnd();
            b        = rnd();
            op_sub   = 1'($urandom);
            cin      = 1'($urandom);
            in_valid = ($urandom % 8) != 0;
            @(posedge clk);
            #1;
            guard++;
        end
        if ((n_acc - n0) < 10000) begin
            n_tests++;
            n_fail++;
            $display("FAIL random_budget: got %0d accepted expected 10000",
                     n_acc - n0);
        end
        rnd_phase = 1'b0;
        in_valid  = 1'b0;
        @(posedge clk);
        #3;
        out_ready = 1'b1;
        guard     = 0;
        while (busy && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        @(negedge clk);
        chk("drained_idle", busy, 1'b0);
        chk("drained_queue", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
